adder_tree_arbiter: RTL and testbench
=====================================

# adder_tree_arbiter

Shares one pipelined 8-operand adder tree among NUM_REQ requesters. Each requester presents a packed set of eight unsigned operands under a valid/ready handshake. A round-robin arbiter grants one requester per cycle, and the selected set moves through an operand register, the tree, and a result register. Each result leaves with the requester ID and has output backpressure. The block sits between the adder-tree datapath and its clients.

## Interface
- ADDER_WIDTH, 13, operand width W
- NUM_REQ, 4, number of requesters (≥1)
- ID_W, $clog2(NUM_REQ) (min 1), width of out_id

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester valid
- req_ready  out  NUM_REQ  per-requester ready, one-hot or zero
- req_data  in  NUM_REQ*8*W  operand k of requester r at [(r*8+k)*W +: W]
- cfg_levels  in  2  2'd2 = 2-level sum (ops 0–3), any other value = 3-level sum (ops 0–7); sampled with the accepted transaction
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_sum  out  W+3  unsigned sum
- out_id  out  ID_W  requester that owns out_sum
- busy  out  1  any pipeline stage occupied

## Operation
- Arbiter:
  - Round-robin pointer `last`. Priority starts at last+1 and wraps.
  - A grant is issued only when S1 can load.
  - req_ready[r] = grant[r]. It depends combinationally on req_valid, so requesters must not gate valid on ready.
  - Handshake: req_valid[r] & req_ready[r]. `last` updates only on a handshake.
- S1 (operand stage):
  - Fields: s1_valid, id, levels, eight W-bit operands.
  - Loads when !s1_valid or S2 loads.
  - s1_valid next = handshake occurred.
- Tree (combinational from S1):
  - Operands are zero-extended. Pairwise sums give four W+1-bit values, then two W+2-bit values, then one W+3-bit value.
  - 2-level result = zero-extended sum of ops 0–3.
  - 3-level result = sum of all eight.
  - No overflow is possible: 8·(2^W−1) < 2^(W+3).
- S2 (result stage): drives out_valid/out_sum/out_id.
  - Loads when !s2_valid or out_ready.
  - s2_valid next = s1_valid.
- Output handshake: out_valid & out_ready. out_sum and out_id hold stable while out_valid & !out_ready.
- busy = s1_valid | s2_valid.
- No transaction is dropped, duplicated or reordered. Results leave in grant order.

## Timing
- Reset (async assert, deassert sampled on clk):
  - s1_valid = s2_valid = 0, out_valid = 0, out_sum = 0, out_id = 0, busy = 0.
  - `last` = NUM_REQ−1, so requester 0 has top priority.
  - req_ready is 0 while rst is high.
- Latency:
  - Handshake at edge N, out_valid high after edge N+1.
  - Result is consumable at edge N+2 if out_ready.
- Throughput: one transaction per cycle while out_ready = 1.
- Backpressure:
  - With out_ready = 0, S2 holds, then S1 fills, then all req_ready go 0 in the same cycle S1 becomes blocked.
  - When out_ready rises, S2, S1 and the arbiter all advance in that cycle, so there is no bubble.
- Simultaneous events:
  - Output handshake plus a new S1 result in the same cycle: S2 reloads, so out_valid stays high.
  - Several valids at once: exactly one grant.
- A requester that drops valid before being granted loses nothing. Grant order follows the pointer.
- Reset mid-operation: in-flight transactions are discarded and the pointer is reset. No partial output appears.

## Structure
- Package adder_tree_pkg:
  - ADDER_WIDTH default, NUM_OPS = 8.
  - Level-select constants LVL2 = 2'd2, LVL3 = 2'd3.
  - Function for ID width.
- Sub-module rr_arbiter:
  - Parameter N.
  - Ports: req, en (S1 can load), grant one-hot, registered pointer with async reset.
- The tree is built from the existing adder_tree_branch instances, EXTRA_BITS 0/1/2.
- Top contains S1/S2 registers, operand mux and output logic.

## Test plan
- Reset then single request: r2 sends ops 1..8, levels 3, out_ready = 1.
  - Expected: req_ready[2] = 1 in the same cycle; out_valid two edges later with out_sum = 36, out_id = 2.
- Level select: ops 1..8 with cfg_levels = 2 → out_sum = 10. All-ones operands with levels 3 → out_sum = 65528 (W = 13).
- Fairness: all four requesters hold valid for 8 cycles.
  - Expected: grants 0,1,2,3,0,1,2,3 and out_id follows the same order, one per cycle.
- Backpressure: stream from r1 with out_ready low for 5 cycles.
  - Expected: exactly 2 transactions accepted, then req_ready = 0.
  - On release, all results emerge in order and no values are lost or duplicated.
- Reset mid-flight: assert rst while S1 and S2 are full.
  - Expected: out_valid = 0 immediately (async).
  - After release, requester 0 wins over requester 3 when both request.

Source files
------------

// File: rtl/adder_tree_arbiter_pkg.sv
// Shared constants and helpers for the shared 8-operand adder tree block.
package adder_tree_pkg;

    localparam int DEFAULT_ADDER_WIDTH = 13;
    localparam int NUM_OPS = 8;

    // Level-select encodings for cfg_levels; every value other than LVL2 sums all eight operands.
    localparam logic [1:0] LVL2 = 2'd2;
    localparam logic [1:0] LVL3 = 2'd3;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_tree_arbiter_if.sv
// Request/result bus between the adder tree arbiter and its clients.
interface adder_tree_arbiter_if
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = id_width(NUM_REQ)
);

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ*NUM_OPS*ADDER_WIDTH-1:0] req_data;
    logic [1:0]                             cfg_levels;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [ADDER_WIDTH+2:0]                 out_sum;
    logic [ID_W-1:0]                        out_id;

    modport master (
        output req_valid, req_data, cfg_levels, out_ready,
        input  req_ready, out_valid, out_sum, out_id
    );

    modport slave (
        input  req_valid, req_data, cfg_levels, out_ready,
        output req_ready, out_valid, out_sum, out_id
    );

endinterface

// File: rtl/adder_tree_arbiter_arb.sv
// Round-robin arbiter: priority begins just after the last granted requester.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    logic [PW-1:0] last;
    logic [PW-1:0] next_last;

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant     = '0;
        next_last = last;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(last) + 1 + i) % N);
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                next_last  = idx;
                found      = 1'b1;
            end
        end
    end

    // A grant only goes to a valid requester, so any grant is a completed handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= PW'(N - 1);
        end else if (|grant) begin
            last <= next_last;
        end
    end

endmodule

// File: rtl/adder_tree_branch.sv
// One two-input node of the adder tree; the result grows by one bit.
module adder_tree_branch #(
    parameter int ADDER_WIDTH = 13,
    parameter int EXTRA_BITS  = 0
) (
    input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] a,
    input  logic [ADDER_WIDTH+EXTRA_BITS-1:0] b,
    output logic [ADDER_WIDTH+EXTRA_BITS:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_tree_arbiter.sv
// Shares one pipelined 8-operand adder tree among NUM_REQ requesters:
// arbiter -> operand register (S1) -> tree -> result register (S2).
module adder_tree_arbiter
    import adder_tree_pkg::*;
#(
    parameter int ADDER_WIDTH = DEFAULT_ADDER_WIDTH,
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = id_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_tree_arbiter_if.slave  bus,
    output logic                 busy
);

    localparam int W    = ADDER_WIDTH;
    localparam int SW   = W + 3;
    localparam int SETW = NUM_OPS * W;

    logic               s1_valid;
    logic [ID_W-1:0]    s1_id;
    logic [1:0]         s1_levels;
    logic [SETW-1:0]    s1_ops;
    logic               s2_valid;
    logic [SW-1:0]      s2_sum;
    logic [ID_W-1:0]    s2_id;

    logic               s1_load;
    logic               s2_load;
    logic               hs;
    logic [NUM_REQ-1:0] grant;
    logic [SETW-1:0]    sel_ops;
    logic [ID_W-1:0]    sel_id;

    assign s2_load = !s2_valid || bus.out_ready;
    assign s1_load = !s1_valid || s2_load;
    assign hs      = |grant;

    // Holding en low during reset keeps every req_ready at zero while rst is high.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (bus.req_valid),
        .en    (s1_load && !rst),
        .grant (grant)
    );

    assign bus.req_ready = grant;

    always_comb begin
        sel_ops = '0;
        sel_id  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant[r]) begin
                sel_ops = bus.req_data[r*SETW +: SETW];
                sel_id  = ID_W'(r);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_id     <= '0;
            s1_levels <= LVL3;
            s1_ops    <= '0;
        end else if (s1_load) begin
            s1_valid <= hs;
            if (hs) begin
                s1_id     <= sel_id;
                s1_levels <= bus.cfg_levels;
                s1_ops    <= sel_ops;
            end
        end
    end

    logic [W:0]   sum_l1 [4];
    logic [W+1:0] sum_l2 [2];
    logic [W+2:0] sum_l3;
    logic [SW-1:0] tree_sum;

    for (genvar g = 0; g < 4; g++) begin : g_l1
        adder_tree_branch #(.ADDER_WIDTH(W), .EXTRA_BITS(0)) u_br (
            .a   (s1_ops[(2*g)*W +: W]),
            .b   (s1_ops[(2*g+1)*W +: W]),
            .sum (sum_l1[g])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_l2
        adder_tree_branch #(.ADDER_WIDTH(W), .EXTRA_BITS(1)) u_br (
            .a   (sum_l1[2*g]),
            .b   (sum_l1[2*g+1]),
            .sum (sum_l2[g])
        );
    end

    adder_tree_branch #(.ADDER_WIDTH(W), .EXTRA_BITS(2)) u_br_l3 (
        .a   (sum_l2[0]),
        .b   (sum_l2[1]),
        .sum (sum_l3)
    );

    assign tree_sum = (s1_levels == LVL2) ? SW'(sum_l2[0]) : sum_l3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_id    <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum <= tree_sum;
                s2_id  <= s1_id;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = s2_sum;
    assign bus.out_id    = s2_id;
    assign busy          = s1_valid || s2_valid;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Scoreboard bench for adder_tree_arbiter: handshakes push expected results, a monitor pops and compares.
module tb_adder_tree_arbiter;
    import adder_tree_pkg::*;

    localparam int W    = 13;
    localparam int NR   = 4;
    localparam int IDW  = 2;
    localparam int SETW = NUM_OPS * W;

    typedef struct {
        int id;
        int sum;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;

    adder_tree_arbiter_if #(.ADDER_WIDTH(W), .NUM_REQ(NR), .ID_W(IDW)) bus ();

    adder_tree_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(NR), .ID_W(IDW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;
    int   exp_sum [NR];
    exp_t exp_q [$];
    exp_t mon_e;
    logic held_valid = 1'b0;
    int   held_sum;
    int   held_id;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [SETW-1:0] packOps(input int base, input int step);
        logic [SETW-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_OPS; k++) v[k*W +: W] = W'(base + k * step);
        return v;
    endfunction

    task automatic applyStimulus(input int r, input logic [SETW-1:0] ops,
                                 input logic [1:0] lev, input int expected);
        bus.req_data[r*SETW +: SETW] = ops;
        bus.cfg_levels               = lev;
        exp_sum[r]                   = expected;
        bus.req_valid[r]             = 1'b1;
    endtask

    task automatic dropValid(input int r);
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitHandshake(input int r);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_valid[r] && bus.req_ready[r]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checkOutput($sformatf("handshake_r%0d", r), int'(ok), 1);
    endtask

    task automatic drainPipe(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput(name, int'(ok), 1);
    endtask

    // Every accepted request turns into one expected result, in grant order.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
            for (int r = 0; r < NR; r++) begin
                if (bus.req_valid[r] && bus.req_ready[r]) exp_q.push_back('{id: r, sum: exp_sum[r]});
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else begin
            if (held_valid) begin
                checkOutput("hold_sum", int'(bus.out_sum), held_sum);
                checkOutput("hold_id", int'(bus.out_id), held_id);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("out_id", int'(bus.out_id), mon_e.id);
                    checkOutput("out_sum", int'(bus.out_sum), mon_e.sum);
                    pops++;
                end
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held_sum   = int'(bus.out_sum);
            held_id    = int'(bus.out_id);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int k;
        int pops_before;
        logic hs;

        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.cfg_levels = LVL3;
        bus.out_ready  = 1'b1;
        for (int r = 0; r < NR; r++) exp_sum[r] = 0;

        repeat (2) @(posedge clk);
        #1 bus.req_valid = 4'b0001;
        @(negedge clk);
        checkOutput("reset_ready", int'(bus.req_ready), 0);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_out_sum", int'(bus.out_sum), 0);
        checkOutput("reset_out_id", int'(bus.out_id), 0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;

        $display("[TB] single request from r2");
        applyStimulus(2, packOps(1, 1), LVL3, 36);
        @(negedge clk);
        checkOutput("t1_ready_same_cycle", int'(bus.req_ready), 4'b0100);
        tick();
        dropValid(2);
        @(negedge clk);
        checkOutput("t1_valid_after_n", int'(bus.out_valid), 0);
        checkOutput("t1_busy", int'(busy), 1);
        tick();
        @(negedge clk);
        checkOutput("t1_valid_after_n1", int'(bus.out_valid), 1);
        tick();
        @(negedge clk);
        checkOutput("t1_valid_consumed", int'(bus.out_valid), 0);

        $display("[TB] level select");
        tick();
        applyStimulus(0, packOps(1, 1), LVL2, 10);
        waitHandshake(0);
        tick();
        dropValid(0);
        applyStimulus(3, packOps(8191, 0), LVL3, 65528);
        waitHandshake(3);
        tick();
        dropValid(3);
        drainPipe("drain_levels");

        $display("[TB] fairness");
        tick();
        for (int r = 0; r < NR; r++) applyStimulus(r, packOps(r + 1, 0), LVL3, 8 * (r + 1));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput($sformatf("fair_grant%0d", c), int'(bus.req_ready), 1 << (c % 4));
            tick();
        end
        for (int r = 0; r < NR; r++) dropValid(r);
        drainPipe("drain_fair");

        $display("[TB] backpressure");
        tick();
        pops_before   = pops;
        bus.out_ready = 1'b0;
        k = 1;
        applyStimulus(1, packOps(k, 0), LVL3, 8 * k);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            hs = bus.req_ready[1];
            checkOutput($sformatf("bp_ready%0d", c), int'(hs), (c < 2) ? 1 : 0);
            tick();
            if (hs) begin
                k++;
                applyStimulus(1, packOps(k, 0), LVL3, 8 * k);
            end
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            hs = bus.req_ready[1];
            if (c == 0) checkOutput("bp_release_no_bubble", int'(hs), 1);
            tick();
            if (hs) begin
                k++;
                applyStimulus(1, packOps(k, 0), LVL3, 8 * k);
            end
        end
        dropValid(1);
        drainPipe("drain_bp");
        checkOutput("bp_accepted", k - 1, 6);
        checkOutput("bp_results", pops - pops_before, 6);

        $display("[TB] reset mid-flight");
        tick();
        bus.out_ready = 1'b0;
        applyStimulus(1, packOps(9, 0), LVL3, 72);
        repeat (2) tick();
        dropValid(1);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", int'(bus.out_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_ready", int'(bus.req_ready), 0);
        exp_q.delete();
        @(negedge clk);
        tick();
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        applyStimulus(0, packOps(2, 0), LVL3, 16);
        applyStimulus(3, packOps(3, 0), LVL3, 24);
        @(negedge clk);
        checkOutput("midrst_r0_first", int'(bus.req_ready), 4'b0001);
        tick();
        dropValid(0);
        @(negedge clk);
        checkOutput("midrst_r3_next", int'(bus.req_ready), 4'b1000);
        tick();
        dropValid(3);
        drainPipe("drain_midrst");

        checkOutput("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
